xu_gpr_wrarb: RTL

Write-port arbiter and scheduler for the XU GPR array. It accepts register writebacks from up to six result sources (ALU pipes, load return, mul/div, SPR moves) through valid/ready handshakes and buffers each source in a 2-entry FIFO. Each cycle it schedules up to four writes onto the array's four write ports with round-robin fairness, and appends per-byte parity so that read-side parity checking stays consistent. It sits between the XU result buses and the GPR array write ports.

---
 rtl/xu_gpr_wrarb_if.sv | 34 +++
 rtl/xu_gpr_wrarb.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/xu_gpr_wrarb_if.sv
// Bundle between the XU result sources and the GPR write ports.
// master: result-source side (drives requests, sees ready and port outputs).
// slave:  arbiter side.
// Handshake: a requester transfer happens at the rising edge where
// req_val[k] and req_rdy[k] are both high. req_rdy depends only on
// registered state, so a requester may raise req_val at any time and must
// hold its payload steady until the edge that completes the transfer.
interface xu_gpr_wrarb_if #(
  parameter int N_REQ     = 6,
  parameter int N_WP      = 4,
  parameter int ADDR_W    = 7,
  parameter int GPR_WIDTH = 64,
  parameter int DATA_W    = GPR_WIDTH + GPR_WIDTH/8 + 2
);
  logic [N_REQ-1:0]           req_val;
  logic [N_REQ-1:0]           req_rdy;
  logic [N_REQ*ADDR_W-1:0]    req_addr;
  logic [N_REQ*GPR_WIDTH-1:0] req_data;
  logic [N_REQ*2-1:0]         req_tag;
  logic [N_WP-1:0]            w_e;
  logic [N_WP*ADDR_W-1:0]     w_a;
  logic [N_WP*DATA_W-1:0]     w_d;
  logic                       arb_idle;

  modport master (
    output req_val, req_addr, req_data, req_tag,
    input  req_rdy, w_e, w_a, w_d, arb_idle
  );

  modport slave (
    input  req_val, req_addr, req_data, req_tag,
    output req_rdy, w_e, w_a, w_d, arb_idle
  );
endinterface

// File: rtl/xu_gpr_wrarb.sv
// GPR write-port arbiter: one 2-entry FIFO per result source, round-robin
// scheduling of up to N_WP heads per cycle onto the write ports, with
// same-address heads deferred so no two ports ever carry one address.
// Port word = {data, par[0:NB-1], tag}; par[0] covers the MSB data byte.
module xu_gpr_wrarb #(
  parameter int N_REQ     = 6,
  parameter int N_WP      = 4,
  parameter int ADDR_W    = 7,
  parameter int GPR_WIDTH = 64,
  parameter int DATA_W    = GPR_WIDTH + GPR_WIDTH/8 + 2
) (
  input  logic          nclk,
  input  logic          reset_b,
  xu_gpr_wrarb_if.slave bus
);

  localparam int NB   = GPR_WIDTH / 8;
  localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Even parity per byte, byte 0 being the most-significant byte.
  function automatic logic [NB-1:0] byte_par(input logic [GPR_WIDTH-1:0] d);
    logic [NB-1:0] p;
    for (int i = 0; i < NB; i++) begin
      p[NB-1-i] = ^d[GPR_WIDTH-1-8*i -: 8];
    end
    return p;
  endfunction

  // FIFO storage and pointers
  logic [ADDR_W-1:0]    r_addr [N_REQ][2];
  logic [GPR_WIDTH-1:0] r_data [N_REQ][2];
  logic [1:0]           r_tag  [N_REQ][2];
  logic [N_REQ-1:0]     r_wptr;
  logic [N_REQ-1:0]     r_rptr;
  logic [1:0]           r_cnt  [N_REQ];
  logic [N_REQ-1:0]     r_rdy;
  logic [RR_W-1:0]      r_rr;

  // Port output registers
  logic [N_WP-1:0]        r_we;
  logic [N_WP*ADDR_W-1:0] r_wa;
  logic [N_WP*DATA_W-1:0] r_wd;
  logic                   r_idle;

  // Combinational scheduling signals
  logic [N_REQ-1:0]  w_push;
  logic [N_REQ-1:0]  w_pop;
  logic [ADDR_W-1:0] w_head_addr [N_REQ];
  logic [DATA_W-1:0] w_head_word [N_REQ];
  logic [RR_W-1:0]   w_idx       [N_REQ];
  logic [RR_W-1:0]   w_sel_req   [N_WP];
  logic [ADDR_W-1:0] w_sel_addr  [N_WP];
  logic [1:0]        w_cnt_nxt   [N_REQ];
  logic [RR_W-1:0]   w_rr_nxt;
  logic              w_idle_nxt;
  logic              w_conf;
  int                w_nsel;
  int                w_s;

  assign w_push       = bus.req_val & r_rdy;
  assign bus.req_rdy  = r_rdy;
  assign bus.w_e      = r_we;
  assign bus.w_a      = r_wa;
  assign bus.w_d      = r_wd;
  assign bus.arb_idle = r_idle;

  // Head entry of every FIFO, with parity attached, ready for a port.
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      w_head_addr[k] = r_addr[k][r_rptr[k]];
      w_head_word[k] = {r_data[k][r_rptr[k]], byte_par(r_data[k][r_rptr[k]]),
                        r_tag[k][r_rptr[k]]};
    end
  end

  // Requester visiting order this cycle: rr, rr+1, ... wrapping at N_REQ.
  always_comb begin
    w_s = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_s = int'(r_rr) + i;
      if (w_s >= N_REQ) w_s = w_s - N_REQ;
      w_idx[i] = RR_W'(w_s);
    end
  end

  // Greedy scan: take each non-empty head unless ports are full or its
  // address is already claimed this cycle; the skipped head simply waits.
  always_comb begin
    w_pop    = '0;
    w_nsel   = 0;
    w_rr_nxt = r_rr;
    w_conf   = 1'b0;
    for (int p = 0; p < N_WP; p++) begin
      w_sel_req[p]  = '0;
      w_sel_addr[p] = '0;
    end
    for (int i = 0; i < N_REQ; i++) begin
      w_conf = 1'b0;
      for (int p = 0; p < N_WP; p++) begin
        if ((p < w_nsel) && (w_sel_addr[p] == w_head_addr[w_idx[i]])) w_conf = 1'b1;
      end
      if ((r_cnt[w_idx[i]] != 2'd0) && (w_nsel < N_WP) && !w_conf) begin
        for (int p = 0; p < N_WP; p++) begin
          if (p == w_nsel) begin
            w_sel_req[p]  = w_idx[i];
            w_sel_addr[p] = w_head_addr[w_idx[i]];
          end
        end
        w_pop[w_idx[i]] = 1'b1;
        w_nsel          = w_nsel + 1;
        w_rr_nxt        = (w_idx[i] == RR_W'(N_REQ-1)) ? '0 : w_idx[i] + RR_W'(1);
      end
    end
  end

  // Next FIFO occupancy and the idle flag that follows from it.
  always_comb begin
    w_idle_nxt = (w_nsel == 0);
    for (int k = 0; k < N_REQ; k++) begin
      w_cnt_nxt[k] = r_cnt[k] + 2'(w_push[k]) - 2'(w_pop[k]);
      if (w_cnt_nxt[k] != 2'd0) w_idle_nxt = 1'b0;
    end
  end

  // FIFO push/pop, occupancy, ready and round-robin pointer.
  always_ff @(posedge nclk or negedge reset_b) begin
    if (!reset_b) begin
      for (int k = 0; k < N_REQ; k++) begin
        for (int e = 0; e < 2; e++) begin
          r_addr[k][e] <= '0;
          r_data[k][e] <= '0;
          r_tag[k][e]  <= '0;
        end
        r_cnt[k] <= 2'd0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_rdy  <= '0;
      r_rr   <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (w_push[k]) begin
          r_addr[k][r_wptr[k]] <= bus.req_addr[k*ADDR_W +: ADDR_W];
          r_data[k][r_wptr[k]] <= bus.req_data[k*GPR_WIDTH +: GPR_WIDTH];
          r_tag[k][r_wptr[k]]  <= bus.req_tag[k*2 +: 2];
          r_wptr[k]            <= ~r_wptr[k];
        end
        if (w_pop[k]) r_rptr[k] <= ~r_rptr[k];
        r_cnt[k] <= w_cnt_nxt[k];
        r_rdy[k] <= (w_cnt_nxt[k] != 2'd2);
      end
      r_rr <= w_rr_nxt;
    end
  end

  // Load selected heads onto ports in selection order; idle ports hold a/d.
  always_ff @(posedge nclk or negedge reset_b) begin
    if (!reset_b) begin
      r_we   <= '0;
      r_wa   <= '0;
      r_wd   <= '0;
      r_idle <= 1'b1;
    end else begin
      for (int p = 0; p < N_WP; p++) begin
        r_we[p] <= (p < w_nsel);
        if (p < w_nsel) begin
          r_wa[p*ADDR_W +: ADDR_W] <= w_head_addr[w_sel_req[p]];
          r_wd[p*DATA_W +: DATA_W] <= w_head_word[w_sel_req[p]];
        end
      end
      r_idle <= w_idle_nxt;
    end
  end

endmodule
